pool_channel_scheduler: RTL and testbench
=========================================

Name: pool_channel_scheduler

Overview:
Sequences up to NUM_CH input feature-map channels through the single shared 6x6 -> 3x3 average-pool layer in the CNN core. For each enabled channel it resets the pool layer, pulses its start, waits for done with a timeout guard, then strobes a write so the downstream output buffer captures the 9-word result for that channel. One start request processes all channels selected by the mask, in ascending index order.

Parameters:
NUM_CH, 4, number of channels (1..16)
CH_W, 2, width of channel index (clog2(NUM_CH), minimum 1)
TIMEOUT, 255, max cycles to wait for pool done before flagging error (1..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled only in IDLE
ch_mask  in  NUM_CH  channel enable bits; latched on accepted start
pool_done  in  1  done level from the pool layer
pool_rst  out  1  reset to the pool layer (one-cycle pulse per channel)
pool_start  out  1  start to the pool layer (one-cycle pulse per channel)
ch_sel  out  CH_W  channel currently routed to the pool input mux
wr_en  out  1  one-cycle strobe: output buffer captures the pool result into slot wr_ch
wr_ch  out  CH_W  destination channel for wr_en
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse at job completion
error  out  1  sticky timeout flag
ch_count  out  CH_W+1  channels completed in the current/last job

Behaviour:
- Reset: state=IDLE. pool_rst=1 during any cycle rst is high and for one cycle after, so the pool layer is always cleared. All other outputs =0; the latched mask and timeout counter =0. Reset mid-job aborts immediately. No wr_en or done is issued.
- States: IDLE, SCAN, PRST, PSTART, WAIT, CAPTURE, FINISH, ERR.
- IDLE: when start=1, latch ch_mask into pend, clear ch_count and error, set busy, go to SCAN. If start=1 with ch_mask=0, go to SCAN; it finds no channels, so done pulses 2 cycles after start.
- SCAN (1 cycle): if pend is nonzero, set ch_sel to the lowest set bit and go to PRST. Otherwise go to FINISH.
- PRST: pool_rst=1 for exactly 1 cycle, then go to PSTART.
- PSTART: pool_start=1 for exactly 1 cycle, clear the timeout counter, then go to WAIT.
- WAIT: ignore pool_done in the first WAIT cycle (blanking for a stale done). From the second cycle on, pool_done=1 sends the FSM to CAPTURE. The counter increments every WAIT cycle. If it reaches TIMEOUT without an accepted done, go to ERR. A done and a timeout in the same cycle count as done.
- CAPTURE (1 cycle): wr_en=1, wr_ch=ch_sel, clear pend[ch_sel], ch_count+1, go to SCAN.
- FINISH (1 cycle): done=1, busy=0 from the next cycle, go to IDLE.
- ERR (1 cycle): error=1 (sticky until the next accepted start or rst), pool_rst=1, pend cleared, done=1, go to IDLE. The timed-out channel gets no wr_en.
- ch_sel holds its value from SCAN through CAPTURE. It holds its last value while in IDLE.
- start is ignored while busy. The mask is not re-sampled mid-job.
- Per-channel overhead: SCAN + PRST + PSTART + CAPTURE = 4 cycles plus WAIT time.
- Counter widths: the timeout counter is 16 bits and saturates. ch_count never exceeds NUM_CH.

Test Plan:
- rst held 3 cycles, then released -> all outputs 0 except pool_rst, which is 1 through the cycle after release; FSM in IDLE.
- start with ch_mask=4'b1111, stub asserts pool_done 20 cycles after each pool_start -> wr_ch sequence 0,1,2,3; 4 wr_en pulses; ch_count=4; one done pulse; error=0.
- start with ch_mask=4'b1010 -> only channels 1 and 3 processed; exactly 2 pool_start pulses; ch_count=2.
- start with ch_mask=0 -> done pulses 2 cycles after start; no pool_start, no wr_en; ch_count=0.
- Stale pool_done held high from the previous job, start with mask=4'b0001 -> blanking cycle ignores it; with stub done after 20 cycles, wr_en occurs only after the real done.
- TIMEOUT=8, stub never asserts done, mask=4'b0011 -> ERR after 8 WAIT cycles on channel 0; error=1; done pulse; no wr_en; channel 1 never started. Then rst mid-job on a new run -> abort, busy=0 next cycle, error=0.

Source files
------------

// File: rtl/pool_channel_scheduler.sv
// Runs each enabled channel through the shared 6x6->3x3 average-pool layer, lowest index first.
// Latency: 4 cycles per channel plus pool WAIT time, +2 per job; no backpressure (start ignored while busy).
module pool_channel_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              pool_done,
    output logic              pool_rst,
    output logic              pool_start,
    output logic [CH_W-1:0]   ch_sel,
    output logic              wr_en,
    output logic [CH_W-1:0]   wr_ch,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CH_W:0]     ch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_PRST,
        S_PSTART,
        S_WAIT,
        S_CAPTURE,
        S_FINISH,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   ch_sel_q;
    logic [CH_W:0]     ch_count_q;
    logic              error_q;
    logic [15:0]       tcnt;
    logic              rst_q;

    logic [CH_W-1:0]   low_idx;
    logic [16:0]       tcnt_inc;
    logic [15:0]       tcnt_sat;
    logic              timeout_hit;
    logic              done_ok;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    // The first WAIT cycle has tcnt==0; a done seen then may be stale from the previous channel.
    assign tcnt_inc    = {1'b0, tcnt} + 17'd1;
    assign tcnt_sat    = tcnt_inc[16] ? tcnt : tcnt_inc[15:0];
    assign timeout_hit = (tcnt_inc >= 17'(TIMEOUT));
    assign done_ok     = pool_done && (tcnt != 16'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SCAN;
            S_SCAN:    state_nxt = (|pend) ? S_PRST : S_FINISH;
            S_PRST:    state_nxt = S_PSTART;
            S_PSTART:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_ok) begin
                    state_nxt = S_CAPTURE;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_CAPTURE: state_nxt = S_SCAN;
            S_FINISH:  state_nxt = S_IDLE;
            S_ERR:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pend       <= '0;
            ch_sel_q   <= '0;
            ch_count_q <= '0;
            error_q    <= 1'b0;
            tcnt       <= '0;
            rst_q      <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pend       <= ch_mask;
                        ch_count_q <= '0;
                        error_q    <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (|pend) begin
                        ch_sel_q <= low_idx;
                    end
                end
                S_PSTART: tcnt <= '0;
                S_WAIT:   tcnt <= tcnt_sat;
                S_CAPTURE: begin
                    pend <= pend & ~(NUM_CH'(1) << ch_sel_q);
                    if (ch_count_q != (CH_W+1)'(NUM_CH)) begin
                        ch_count_q <= ch_count_q + (CH_W+1)'(1);
                    end
                end
                S_ERR: begin
                    error_q <= 1'b1;
                    pend    <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while rst is high so a mid-job reset never leaks a strobe.
    assign pool_rst   = rst | rst_q | (state == S_PRST) | (state == S_ERR);
    assign pool_start = ~rst & (state == S_PSTART);
    assign wr_en      = ~rst & (state == S_CAPTURE);
    assign done       = ~rst & ((state == S_FINISH) | (state == S_ERR));
    assign busy       = ~rst & (state != S_IDLE);
    assign error      = ~rst & (error_q | (state == S_ERR));
    assign ch_sel     = rst ? '0 : ch_sel_q;
    assign wr_ch      = rst ? '0 : ch_sel_q;
    assign ch_count   = rst ? '0 : ch_count_q;

endmodule

// File: tb/tb_pool_channel_scheduler.sv
// Directed bench for pool_channel_scheduler: a pool stub raises done 20 cycles after each pool_start
// and drops it lazily two cycles later; a second instance with TIMEOUT=8 covers the error path.
module tb_pool_channel_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, pool_done;
    logic [3:0] ch_mask;
    logic       pool_rst, pool_start, wr_en, busy, done, error;
    logic [1:0] ch_sel, wr_ch;
    logic [2:0] ch_count;

    logic       rst2, start2, pool_done2;
    logic [3:0] ch_mask2;
    logic       pool_rst2, pool_start2, wr_en2, busy2, done2, error2;
    logic [1:0] ch_sel2, wr_ch2;
    logic [2:0] ch_count2;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int stub_cnt = 0;
    int stub_clr = 0;
    int t0;
    int ps_cyc[$];
    int wr_cyc[$];
    int done_cyc[$];
    logic [1:0] wr_ch_q[$];
    int ps2_n = 0;
    int wr2_n = 0;
    int done2_cyc[$];

    pool_channel_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .pool_done(pool_done),
        .pool_rst(pool_rst), .pool_start(pool_start), .ch_sel(ch_sel), .wr_en(wr_en),
        .wr_ch(wr_ch), .busy(busy), .done(done), .error(error), .ch_count(ch_count)
    );

    pool_channel_scheduler #(.TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst2), .start(start2), .ch_mask(ch_mask2), .pool_done(pool_done2),
        .pool_rst(pool_rst2), .pool_start(pool_start2), .ch_sel(ch_sel2), .wr_en(wr_en2),
        .wr_ch(wr_ch2), .busy(busy2), .done(done2), .error(error2), .ch_count(ch_count2)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pool stub and event monitor, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (pool_start) begin
            ps_cyc.push_back(cyc);
            stub_cnt = 20;
            stub_clr = 2;
        end else begin
            if (stub_clr > 0) begin
                stub_clr--;
                if (stub_clr == 0) pool_done = 1'b0;
            end
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) pool_done = 1'b1;
            end
        end
        if (wr_en) begin
            wr_cyc.push_back(cyc);
            wr_ch_q.push_back(wr_ch);
        end
        if (done) done_cyc.push_back(cyc);
        if (pool_start2) ps2_n++;
        if (wr_en2) wr2_n++;
        if (done2) done2_cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ps_cyc.delete();
        wr_cyc.delete();
        wr_ch_q.delete();
        done_cyc.delete();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cyc.size() == 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ch_mask = 4'b0; pool_done = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; ch_mask2 = 4'b0; pool_done2 = 1'b0;
        repeat (3) step();
        checks++; if (pool_rst !== 1'b1) $display("FAIL rst_pool_rst_held: got %b want 1", pool_rst); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy_held: got %b want 0", busy); else passed++;
        rst = 1'b0; rst2 = 1'b0;
        checks++; if (pool_rst !== 1'b1) $display("FAIL rst_pool_rst_after: got %b want 1", pool_rst); else passed++;
        checks++; if ({pool_start, wr_en, busy, done, error} !== 5'b0)
            $display("FAIL rst_ctrl_outputs: got %b want 00000", {pool_start, wr_en, busy, done, error}); else passed++;
        checks++; if ({ch_sel, wr_ch, ch_count} !== 7'b0)
            $display("FAIL rst_data_outputs: got %b want 0", {ch_sel, wr_ch, ch_count}); else passed++;
        step();
        checks++; if (pool_rst !== 1'b0) $display("FAIL rst_pool_rst_drop: got %b want 0", pool_rst); else passed++;
        checks++; if (pool_rst2 !== 1'b0) $display("FAIL rst2_pool_rst_drop: got %b want 0", pool_rst2); else passed++;
    endtask

    task automatic test_all_channels();
        clear_logs();
        ch_mask = 4'b1111; start = 1'b1; t0 = cyc;
        step();
        start = 1'b0; ch_mask = 4'b0000;
        checks++; if (busy !== 1'b1) $display("FAIL all_busy: got %b want 1", busy); else passed++;
        repeat (9) step();
        start = 1'b1; ch_mask = 4'b0001;
        step();
        start = 1'b0; ch_mask = 4'b0000;
        wait_done(300);
        checks++; if (done_cyc.size() != 1) $display("FAIL all_done_count: got %0d want 1", done_cyc.size()); else passed++;
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != t0 + 98) $display("FAIL all_done_cycle: got %0d want %0d", done_cyc[0], t0 + 98); else passed++;
        end
        checks++; if (wr_cyc.size() != 4) $display("FAIL all_wr_count: got %0d want 4", wr_cyc.size()); else passed++;
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
            checks++; if (wr_ch_q[i] !== 2'(i)) $display("FAIL all_wr_ch%0d: got %0d want %0d", i, wr_ch_q[i], i); else passed++;
            checks++; if (wr_cyc[i] != t0 + 24 + 24 * i)
                $display("FAIL all_wr_cycle%0d: got %0d want %0d", i, wr_cyc[i], t0 + 24 + 24 * i); else passed++;
        end
        checks++; if (ps_cyc.size() != 4) $display("FAIL all_start_count: got %0d want 4", ps_cyc.size()); else passed++;
        if (ps_cyc.size() > 0) begin
            checks++; if (ps_cyc[0] != t0 + 3) $display("FAIL all_first_start: got %0d want %0d", ps_cyc[0], t0 + 3); else passed++;
        end
        checks++; if (ch_count !== 3'd4) $display("FAIL all_ch_count: got %0d want 4", ch_count); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL all_error: got %b want 0", error); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL all_busy_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_sparse_mask();
        clear_logs();
        ch_mask = 4'b1010; start = 1'b1; t0 = cyc;
        step();
        start = 1'b0;
        wait_done(200);
        checks++; if (ps_cyc.size() != 2) $display("FAIL sparse_start_count: got %0d want 2", ps_cyc.size()); else passed++;
        if (ps_cyc.size() > 0) begin
            checks++; if (ps_cyc[0] != t0 + 3) $display("FAIL sparse_first_start: got %0d want %0d", ps_cyc[0], t0 + 3); else passed++;
        end
        checks++; if (wr_cyc.size() != 2) $display("FAIL sparse_wr_count: got %0d want 2", wr_cyc.size()); else passed++;
        if (wr_cyc.size() == 2) begin
            checks++; if (wr_ch_q[0] !== 2'd1) $display("FAIL sparse_wr_ch0: got %0d want 1", wr_ch_q[0]); else passed++;
            checks++; if (wr_ch_q[1] !== 2'd3) $display("FAIL sparse_wr_ch1: got %0d want 3", wr_ch_q[1]); else passed++;
            checks++; if (wr_cyc[1] != t0 + 48) $display("FAIL sparse_wr_cycle1: got %0d want %0d", wr_cyc[1], t0 + 48); else passed++;
        end
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != t0 + 50) $display("FAIL sparse_done_cycle: got %0d want %0d", done_cyc[0], t0 + 50); else passed++;
        end
        checks++; if (ch_count !== 3'd2) $display("FAIL sparse_ch_count: got %0d want 2", ch_count); else passed++;
        checks++; if (ch_sel !== 2'd3) $display("FAIL sparse_ch_sel_hold: got %0d want 3", ch_sel); else passed++;
    endtask

    task automatic test_empty_mask();
        clear_logs();
        ch_mask = 4'b0000; start = 1'b1; t0 = cyc;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL empty_busy: got %b want 1", busy); else passed++;
        wait_done(20);
        checks++; if (done_cyc.size() != 1) $display("FAIL empty_done_count: got %0d want 1", done_cyc.size()); else passed++;
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != t0 + 2) $display("FAIL empty_done_cycle: got %0d want %0d", done_cyc[0], t0 + 2); else passed++;
        end
        checks++; if (ps_cyc.size() + wr_cyc.size() != 0)
            $display("FAIL empty_no_activity: got %0d want 0", ps_cyc.size() + wr_cyc.size()); else passed++;
        checks++; if (ch_count !== 3'd0) $display("FAIL empty_ch_count: got %0d want 0", ch_count); else passed++;
    endtask

    task automatic test_stale_done();
        clear_logs();
        pool_done = 1'b1;
        repeat (2) step();
        ch_mask = 4'b0001; start = 1'b1; t0 = cyc;
        step();
        start = 1'b0;
        wait_done(100);
        checks++; if (wr_cyc.size() != 1) $display("FAIL stale_wr_count: got %0d want 1", wr_cyc.size()); else passed++;
        if (wr_cyc.size() > 0) begin
            checks++; if (wr_cyc[0] != t0 + 24) $display("FAIL stale_wr_cycle: got %0d want %0d", wr_cyc[0], t0 + 24); else passed++;
            checks++; if (wr_ch_q[0] !== 2'd0) $display("FAIL stale_wr_ch: got %0d want 0", wr_ch_q[0]); else passed++;
        end
        checks++; if (ch_count !== 3'd1) $display("FAIL stale_ch_count: got %0d want 1", ch_count); else passed++;
    endtask

    task automatic test_timeout();
        ch_mask2 = 4'b0011; start2 = 1'b1; t0 = cyc;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 100 && done2_cyc.size() == 0; i++) step();
        step();
        checks++; if (done2_cyc.size() != 1) $display("FAIL to_done_count: got %0d want 1", done2_cyc.size()); else passed++;
        if (done2_cyc.size() > 0) begin
            checks++; if (done2_cyc[0] != t0 + 12) $display("FAIL to_done_cycle: got %0d want %0d", done2_cyc[0], t0 + 12); else passed++;
        end
        checks++; if (ps2_n != 1) $display("FAIL to_start_count: got %0d want 1", ps2_n); else passed++;
        checks++; if (wr2_n != 0) $display("FAIL to_wr_count: got %0d want 0", wr2_n); else passed++;
        checks++; if (error2 !== 1'b1) $display("FAIL to_error_sticky: got %b want 1", error2); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL to_busy: got %b want 0", busy2); else passed++;
        checks++; if (ch_count2 !== 3'd0) $display("FAIL to_ch_count: got %0d want 0", ch_count2); else passed++;
    endtask

    task automatic test_reset_mid_job();
        ch_mask2 = 4'b0011; start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++; if (error2 !== 1'b0) $display("FAIL mid_error_cleared: got %b want 0", error2); else passed++;
        repeat (4) step();
        checks++; if (busy2 !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy2); else passed++;
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        checks++; if (busy2 !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", busy2); else passed++;
        checks++; if (error2 !== 1'b0) $display("FAIL mid_error_after: got %b want 0", error2); else passed++;
        checks++; if (pool_rst2 !== 1'b1) $display("FAIL mid_pool_rst: got %b want 1", pool_rst2); else passed++;
        repeat (20) step();
        checks++; if (done2_cyc.size() != 1) $display("FAIL mid_no_done: got %0d want 1", done2_cyc.size()); else passed++;
        checks++; if (ps2_n != 2 || wr2_n != 0) $display("FAIL mid_no_restart: got %0d/%0d want 2/0", ps2_n, wr2_n); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL mid_idle: got %b want 0", busy2); else passed++;
    endtask

    initial begin
        test_reset();
        test_all_channels();
        test_sparse_mask();
        test_empty_mask();
        test_stale_done();
        test_timeout();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
